// File: rtl/ad9363_tdd_ctrl.sv
// ---------------------------------------------------------------------------
// ad9363_tdd_ctrl
//
// Time-division-duplex scheduler in front of ad9363_stream. It owns the
// AD9363 ENABLE/TXNRX pins and hands the shared radio either to a TX burst
// requester or to a periodic RX capture window. The internal IQ streams are
// gated so that samples only move while the radio is in the matching mode.
//
// Ports
//   clk, rst                       clock, asynchronous active-low reset
//   cfg_rx_len                     RX window length in samples (0 = RX off)
//   tx_req, tx_len                 level burst request and its length
//   tx_ack, tx_done, tx_underrun   one-cycle status pulses
//   src_valid/ready, src_i/q       TX sample source
//   st_in_valid/ready, st_in_i/q   samples towards ad9363_stream
//   st_out_valid/ready, st_out_i/q samples from ad9363_stream
//   sink_valid/ready, sink_i/q     RX sample sink
//   ad_enable, ad_txnrx            registered radio pins (txnrx 1 = TX)
//   state                          current FSM state for debug
//
// Handshakes: a sample transfers on a rising clk edge where valid and ready
// are both high. valid never waits on ready; ready may depend on valid.
// ---------------------------------------------------------------------------
module ad9363_tdd_ctrl #(
    parameter int DATA_W    = 12,
    parameter int LEN_W     = 16,
    parameter int GUARD_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  cfg_rx_len,
    input  logic              tx_req,
    input  logic [LEN_W-1:0]  tx_len,
    output logic              tx_ack,
    output logic              tx_done,
    output logic              tx_underrun,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [DATA_W-1:0] src_i,
    input  logic [DATA_W-1:0] src_q,
    output logic              st_in_valid,
    input  logic              st_in_ready,
    output logic [DATA_W-1:0] st_in_i,
    output logic [DATA_W-1:0] st_in_q,
    input  logic              st_out_valid,
    output logic              st_out_ready,
    input  logic [DATA_W-1:0] st_out_i,
    input  logic [DATA_W-1:0] st_out_q,
    output logic              sink_valid,
    input  logic              sink_ready,
    output logic [DATA_W-1:0] sink_i,
    output logic [DATA_W-1:0] sink_q,
    output logic              ad_enable,
    output logic              ad_txnrx,
    output logic [2:0]        state
);

    // A guard of zero cycles would let data move before the radio settles,
    // so the effective guard is at least one cycle.
    localparam int GUARD_EFF = (GUARD_CYC < 1) ? 1 : GUARD_CYC;
    localparam int GCNT_RAW  = $clog2(GUARD_CYC + 1);
    localparam int GCNT_W    = (GCNT_RAW < 1) ? 1 : GCNT_RAW;
    localparam logic [GCNT_W-1:0] GUARD_LOAD = GCNT_W'(GUARD_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX_GUARD = 3'd1,
        S_TX       = 3'd2,
        S_RX_GUARD = 3'd3,
        S_RX       = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [GCNT_W-1:0]  guard_q;
    logic [GCNT_W-1:0]  guard_d;
    logic [LEN_W-1:0]   rem_q;
    logic [LEN_W-1:0]   rem_d;
    logic               ack_q;
    logic               ack_d;
    logic               zero_done_q;
    logic               zero_done_d;

    logic               tx_active;
    logic               rx_active;
    logic               st_in_hs;
    logic               sink_hs;
    logic               last_sample;

    // -----------------------------------------------------------------------
    // Stream gating: purely combinational from the registered state so the
    // datapath adds no latency.
    // -----------------------------------------------------------------------
    always_comb begin
        tx_active    = (state_q == S_TX);
        rx_active    = (state_q == S_RX);

        st_in_valid  = tx_active;
        st_in_i      = (tx_active && src_valid) ? src_i : '0;
        st_in_q      = (tx_active && src_valid) ? src_q : '0;
        src_ready    = tx_active && src_valid && st_in_ready;
        st_in_hs     = tx_active && st_in_ready;

        // Outside RX the stream output is always drained so that stale
        // samples captured during the guard or while idle are dropped.
        sink_valid   = rx_active && st_out_valid;
        sink_i       = rx_active ? st_out_i : '0;
        sink_q       = rx_active ? st_out_q : '0;
        st_out_ready = rx_active ? sink_ready : 1'b1;
        sink_hs      = rx_active && st_out_valid && sink_ready;

        // rem_q is loaded non-zero on entry, so 1 marks the final sample.
        last_sample  = (rem_q == LEN_W'(1));

        // A starved source still consumes a burst slot: a zero sample goes
        // out and is flagged, keeping the burst length exact.
        tx_underrun  = st_in_hs && !src_valid;
        tx_done      = zero_done_q || (st_in_hs && last_sample);
        tx_ack       = ack_q;
        state        = state_q;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        guard_d     = guard_q;
        rem_d       = rem_q;
        ack_d       = 1'b0;
        zero_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // TX wins over RX when both are eligible.
                if (tx_req) begin
                    ack_d = 1'b1;
                    if (tx_len != '0) begin
                        rem_d   = tx_len;
                        guard_d = GUARD_LOAD;
                        state_d = S_TX_GUARD;
                    end else begin
                        // Empty burst: acknowledge and complete at once.
                        zero_done_d = 1'b1;
                    end
                end else if (cfg_rx_len != '0) begin
                    // Window length is captured here; later edits to
                    // cfg_rx_len only affect the next window.
                    rem_d   = cfg_rx_len;
                    guard_d = GUARD_LOAD;
                    state_d = S_RX_GUARD;
                end
            end

            S_TX_GUARD: begin
                if (guard_q == '0) begin
                    state_d = S_TX;
                end else begin
                    guard_d = guard_q - GCNT_W'(1);
                end
            end

            S_TX: begin
                if (st_in_hs) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (last_sample) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_RX_GUARD: begin
                if (guard_q == '0) begin
                    state_d = S_RX;
                end else begin
                    guard_d = guard_q - GCNT_W'(1);
                end
            end

            S_RX: begin
                // RX runs to completion; a pending tx_req is only looked at
                // once the FSM is back in IDLE.
                if (sink_hs) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (last_sample) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register. The radio pins are registered from the next state so
    // they line up exactly with the state they describe.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            guard_q     <= '0;
            rem_q       <= '0;
            ack_q       <= 1'b0;
            zero_done_q <= 1'b0;
            ad_enable   <= 1'b0;
            ad_txnrx    <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            rem_q       <= rem_d;
            ack_q       <= ack_d;
            zero_done_q <= zero_done_d;
            ad_enable   <= (state_d != S_IDLE);
            ad_txnrx    <= (state_d == S_TX_GUARD) || (state_d == S_TX);
        end
    end

endmodule
